// File: rtl/k8088_sram_pkg.sv
// Shared types and constants for the k8088 SRAM bridge and its prefetch buffer.
package k8088_sram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int WCNT_W = 4;
  localparam logic [WCNT_W-1:0] CNT_ZERO = 4'd0;
  localparam logic [WCNT_W-1:0] CNT_ONE  = 4'd1;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  // {ub_n, lb_n} for a byte lane; only the addressed lane is pulled low.
  localparam logic [1:0] LANE_STB_LO   = 2'b10;
  localparam logic [1:0] LANE_STB_HI   = 2'b01;
  localparam logic [1:0] LANE_STB_NONE = 2'b11;

  function automatic logic [1:0] lane_strobes(input logic lane);
    if (lane == LANE_HI) return LANE_STB_HI;
    else                 return LANE_STB_LO;
  endfunction

  function automatic logic [7:0] select_byte(input logic [15:0] word, input logic lane);
    if (lane == LANE_HI) return word[15:8];
    else                 return word[7:0];
  endfunction

endpackage

// File: rtl/k8088_sram_prefetch.sv
// One-word read buffer {valid, tag, data}: filled by completed SRAM reads,
// patched by writes to the buffered word. Used only with K8088_SRAM_PREFETCH_EN.
module k8088_sram_prefetch
  import k8088_sram_pkg::*;
(
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [18:0] i_lookup_tag,
  output logic        o_hit,
  output logic [15:0] o_data,
  input  logic        i_fill,
  input  logic [18:0] i_fill_tag,
  input  logic [15:0] i_fill_data,
  input  logic        i_wr,
  input  logic [18:0] i_wr_tag,
  input  logic        i_wr_lane,
  input  logic [7:0]  i_wr_byte
);

  logic        r_valid;
  logic [18:0] r_tag;
  logic [15:0] r_data;

  // Buffer state: reset invalidates, fill replaces, matching write patches one byte.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
      r_tag   <= 19'd0;
      r_data  <= 16'h0000;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end else if (i_wr && r_valid && (r_tag == i_wr_tag)) begin
      if (i_wr_lane == LANE_HI) r_data[15:8] <= i_wr_byte;
      else                      r_data[7:0]  <= i_wr_byte;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_data = r_data;

endmodule

// File: rtl/k8088_sram_bridge.sv
// k8088 memory-port responder onto 512Kx16 async SRAM with WAIT_STATES wait cycles.
// Optional one-word read buffer enabled by defining K8088_SRAM_PREFETCH_EN.
module k8088_sram_bridge
  import k8088_sram_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [15:0] RESET_WORD  = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] cpu_address,
  input  logic [7:0]  cpu_out,
  input  logic        cpu_we,
  output logic [7:0]  cpu_in,
  output logic        cpu_chipen,
  output logic [18:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  state_t            r_state;
  state_t            w_next;
  logic [WCNT_W-1:0] r_cnt;
  logic              r_we;
  logic              r_lane;
  logic [7:0]        r_cpu_in;
  logic              r_chipen;
  logic [18:0]       r_sram_addr;
  logic [15:0]       r_dq_o;
  logic              r_dq_oe;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;
  logic              r_ub_n;
  logic              r_lb_n;
  logic              w_hit;
  logic [7:0]        w_hit_byte;

`ifdef K8088_SRAM_PREFETCH_EN
  logic        w_pf_hit;
  logic [15:0] w_pf_data;
  logic        w_fill;
  logic        w_wr_upd;

  assign w_fill   = (r_state == WAIT) && (r_cnt == CNT_ZERO) && !r_we;
  assign w_wr_upd = (r_state == DONE) && r_we;

  k8088_sram_prefetch u_prefetch (
    .i_clock      (clock),
    .i_reset      (reset),
    .i_lookup_tag (cpu_address[19:1]),
    .o_hit        (w_pf_hit),
    .o_data       (w_pf_data),
    .i_fill       (w_fill),
    .i_fill_tag   (r_sram_addr),
    .i_fill_data  (sram_dq_i),
    .i_wr         (w_wr_upd),
    .i_wr_tag     (r_sram_addr),
    .i_wr_lane    (r_lane),
    .i_wr_byte    (r_dq_o[7:0])
  );

  assign w_hit      = w_pf_hit && !cpu_we;
  assign w_hit_byte = select_byte(w_pf_data, cpu_address[0]);
`else
  assign w_hit      = 1'b0;
  assign w_hit_byte = 8'h00;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode; a buffer hit bypasses the SRAM cycle entirely.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_hit) w_next = DONE;
        else       w_next = SETUP;
      end
      SETUP: w_next = WAIT;
      WAIT: begin
        if (r_cnt == CNT_ZERO) w_next = DONE;
        else                   w_next = WAIT;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Registered CPU/SRAM outputs: address, ce and lane lead we_n by one cycle,
  // and reset forces every strobe inactive at once so an aborted write never lands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= CNT_ZERO;
      r_we        <= 1'b0;
      r_lane      <= LANE_LO;
      r_cpu_in    <= RESET_WORD[7:0];
      r_chipen    <= 1'b0;
      r_sram_addr <= 19'd0;
      r_dq_o      <= 16'h0000;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      {r_ub_n, r_lb_n} <= LANE_STB_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          r_we   <= cpu_we;
          r_lane <= cpu_address[0];
          if (w_hit) begin
            r_cpu_in <= w_hit_byte;
            r_chipen <= 1'b1;
          end else begin
            r_sram_addr      <= cpu_address[19:1];
            r_dq_o           <= {cpu_out, cpu_out};
            r_ce_n           <= 1'b0;
            r_oe_n           <= cpu_we;
            {r_ub_n, r_lb_n} <= lane_strobes(cpu_address[0]);
          end
        end
        SETUP: begin
          r_cnt <= WCNT_W'(WAIT_STATES);
          if (r_we) begin
            r_we_n  <= 1'b0;
            r_dq_oe <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == CNT_ZERO) begin
            r_we_n   <= 1'b1;
            r_dq_oe  <= 1'b0;
            r_chipen <= 1'b1;
            if (!r_we) r_cpu_in <= select_byte(sram_dq_i, r_lane);
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        DONE: begin
          r_chipen         <= 1'b0;
          r_dq_oe          <= 1'b0;
          r_ce_n           <= 1'b1;
          r_oe_n           <= 1'b1;
          r_we_n           <= 1'b1;
          {r_ub_n, r_lb_n} <= LANE_STB_NONE;
        end
        default: begin
          r_chipen         <= 1'b0;
          r_dq_oe          <= 1'b0;
          r_ce_n           <= 1'b1;
          r_oe_n           <= 1'b1;
          r_we_n           <= 1'b1;
          {r_ub_n, r_lb_n} <= LANE_STB_NONE;
        end
      endcase
    end
  end

  assign cpu_in     = r_cpu_in;
  assign cpu_chipen = r_chipen;
  assign sram_addr  = r_sram_addr;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_ub_n  = r_ub_n;
  assign sram_lb_n  = r_lb_n;

endmodule

// File: tb/tb_k8088_sram_bridge.sv
// Directed bench for k8088_sram_bridge (WAIT_STATES=2) with a behavioural 512Kx16 SRAM.
module tb_k8088_sram_bridge;

`ifdef K8088_SRAM_PREFETCH_EN
  localparam int HIT_LAT = 1;
  localparam int HIT_CE  = 0;
`else
  localparam int HIT_LAT = 5;
  localparam int HIT_CE  = 5;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] cpu_address = 20'h00000;
  logic [7:0]  cpu_out = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_in;
  logic        cpu_chipen;
  logic [18:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem [0:524287];
  logic        pend_v = 1'b0;
  logic [18:0] pend_a;
  logic [15:0] pend_d;
  logic        pend_ub, pend_lb;

  int n_checks = 0;
  int n_fail   = 0;

  k8088_sram_bridge #(.WAIT_STATES(2), .RESET_WORD(16'h0000)) dut (
    .clock(clock), .reset(reset), .cpu_address(cpu_address), .cpu_out(cpu_out),
    .cpu_we(cpu_we), .cpu_in(cpu_in), .cpu_chipen(cpu_chipen), .sram_addr(sram_addr),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #20 clock = ~clock;

  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  // SRAM write commits on the clocked we_n rising edge; reset discards a pending write.
  always @(posedge clock) begin
    if (reset) begin
      pend_v <= 1'b0;
    end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      pend_v  <= 1'b1;
      pend_a  <= sram_addr;
      pend_d  <= sram_dq_o;
      pend_ub <= !sram_ub_n;
      pend_lb <= !sram_lb_n;
    end else if (pend_v && sram_we_n) begin
      if (pend_ub) mem[pend_a][15:8] <= pend_d[15:8];
      if (pend_lb) mem[pend_a][7:0]  <= pend_d[7:0];
      pend_v <= 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Runs one access starting in IDLE; returns in the IDLE cycle after the chipen pulse.
  task automatic do_access(input logic [19:0] a, input logic we, input logic [7:0] d,
                           output int lat, output int ce_cyc, output int we_cyc,
                           output logic [7:0] rd, output logic [1:0] lanes,
                           output logic [15:0] dq);
    cpu_address = a;
    cpu_we      = we;
    cpu_out     = d;
    lat = 0; ce_cyc = 0; we_cyc = 0; lanes = 2'b11; dq = 16'h0000;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      lat++;
      if (!sram_ce_n) begin ce_cyc++; lanes = {sram_ub_n, sram_lb_n}; end
      if (!sram_we_n) begin we_cyc++; dq = sram_dq_o; end
      if (cpu_chipen) break;
    end
    check_eq("chipen_seen", {31'd0, cpu_chipen}, 32'd1);
    rd = cpu_in;
    @(posedge clock); #1;
    cpu_we = 1'b0;
  endtask

  initial begin
    int lat, ce_cyc, we_cyc;
    logic [7:0] rd;
    logic [1:0] lanes;
    logic [15:0] dq;

    for (int i = 0; i < 524288; i++) mem[i] = 16'h0000;
    mem[19'h091A2] = 16'hABCD;
    mem[19'h00003] = 16'h1234;
    mem[19'h00080] = 16'hBEEF;

    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_chipen", {31'd0, cpu_chipen}, 32'd0);
    check_eq("rst_ce_n",   {31'd0, sram_ce_n},  32'd1);
    check_eq("rst_oe_n",   {31'd0, sram_oe_n},  32'd1);
    check_eq("rst_we_n",   {31'd0, sram_we_n},  32'd1);
    check_eq("rst_dq_oe",  {31'd0, sram_dq_oe}, 32'd0);
    check_eq("rst_cpu_in", {24'd0, cpu_in},     32'h00);
    check_eq("rst_addr",   {13'd0, sram_addr},  32'd0);
    reset = 1'b0;

    do_access(20'h00000, 1'b0, 8'h00, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("first_lat", lat, 32'd5);
    check_eq("first_rd",  {24'd0, rd}, 32'h00);

    do_access(20'h12345, 1'b0, 8'h00, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("rd_hi_data",  {24'd0, rd}, 32'hAB);
    check_eq("rd_hi_lanes", {30'd0, lanes}, 32'h1);
    check_eq("rd_hi_lat",   lat, 32'd5);

    do_access(20'h12344, 1'b0, 8'h00, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("rd_lo_data", {24'd0, rd}, 32'hCD);
    check_eq("rd_lo_lat",  lat, HIT_LAT);

    do_access(20'h00003, 1'b1, 8'h5A, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("wr_lat",       lat, 32'd5);
    check_eq("wr_we_cycles", we_cyc, 32'd3);
    check_eq("wr_lanes",     {30'd0, lanes}, 32'h1);
    check_eq("wr_dq",        {16'd0, dq}, 32'h5A5A);
    check_eq("wr_keeps_in",  {24'd0, rd}, 32'hCD);
    check_eq("wr_mem",       {16'd0, mem[1]}, 32'h5A00);

    do_access(20'h00003, 1'b0, 8'h00, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("wr_readback", {24'd0, rd}, 32'h5A);

    // Abort a write to 00006h during its first WAIT cycle.
    cpu_address = 20'h00006; cpu_we = 1'b1; cpu_out = 8'h99;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check_eq("abort_we_low", {31'd0, sram_we_n}, 32'd0);
    reset = 1'b1;
    #1;
    check_eq("abort_we_n",   {31'd0, sram_we_n},  32'd1);
    check_eq("abort_dq_oe",  {31'd0, sram_dq_oe}, 32'd0);
    check_eq("abort_ce_n",   {31'd0, sram_ce_n},  32'd1);
    check_eq("abort_cpu_in", {24'd0, cpu_in},     32'h00);
    cpu_we = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_eq("abort_mem", {16'd0, mem[3]}, 32'h1234);

    do_access(20'h00003, 1'b0, 8'h00, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("post_rst_lat", lat, 32'd5);
    check_eq("post_rst_rd",  {24'd0, rd}, 32'h5A);
    do_access(20'h00006, 1'b0, 8'h00, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("abort_readback", {24'd0, rd}, 32'h34);

    do_access(20'h00100, 1'b0, 8'h00, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("pf_fill_rd", {24'd0, rd}, 32'hEF);
    do_access(20'h00101, 1'b0, 8'h00, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("pf_hit_rd",  {24'd0, rd}, 32'hBE);
    check_eq("pf_hit_lat", lat, HIT_LAT);
    check_eq("pf_hit_ce",  ce_cyc, HIT_CE);

    do_access(20'h00101, 1'b1, 8'h77, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("pf_wr_lat", lat, 32'd5);
    do_access(20'h00101, 1'b0, 8'h00, lat, ce_cyc, we_cyc, rd, lanes, dq);
    check_eq("pf_upd_rd",  {24'd0, rd}, 32'h77);
    check_eq("pf_upd_lat", lat, HIT_LAT);
    check_eq("pf_upd_mem", {16'd0, mem[19'h00080]}, 32'h77EF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/k8088_sram_bridge.md
Name: k8088_sram_bridge

Overview:
- Bus responder on the far side of the k8088 memory port.
- Accepts the CPU's byte-wide address/data/we and returns read data on the CPU `in` bus.
- Drives the CPU `chipen` as a ready/stall strobe.
- Maps the 1 MB CPU space onto external 512K×16 asynchronous SRAM with a configurable number of wait states.

Parameters:
- WAIT_STATES, 1, extra SRAM access cycles inserted after setup (0..15).
- RESET_WORD, 16'h0000, value held in cpu_in after reset until the first read completes.

Ports:
- clock  in  1  system clock (25 MHz).
- reset  in  1  asynchronous, active-high reset.
- cpu_address  in  20  CPU byte address; stable while cpu_chipen=0.
- cpu_out  in  8  CPU write data.
- cpu_we  in  1  CPU write request for the current address.
- cpu_in  out  8  read data to CPU; registered.
- cpu_chipen  out  1  CPU advance strobe; one-cycle pulse per completed access.
- sram_addr  out  19  SRAM word address = cpu_address[19:1].
- sram_dq_o  out  16  SRAM write data; the byte is replicated to both halves.
- sram_dq_i  in  16  SRAM read data.
- sram_dq_oe  out  1  tristate enable for sram_dq_o.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset (asynchronous) values:
  - state=IDLE, cpu_chipen=0, cpu_in=RESET_WORD[7:0], sram_dq_oe=0.
  - All SRAM strobes=1, sram_addr=0.
  - Prefetch buffer invalid.
- Reset mid-access aborts the access immediately. No SRAM write may occur after reset asserts.
- States: IDLE -> SETUP -> WAIT -> DONE -> IDLE.
- IDLE:
  - Latch cpu_address, cpu_we, cpu_out.
  - Go to SETUP.
- SETUP:
  - Drive sram_addr; sram_ce_n=0.
  - Byte lane: addr[0]=0 selects lb_n=0; addr[0]=1 selects ub_n=0. The other lane stays 1.
  - Read: sram_oe_n=0.
  - Write: sram_dq_oe=1, sram_we_n=0.
  - Load wait counter with WAIT_STATES.
- WAIT:
  - Strobes held; counter decrements.
  - Exit to DONE when counter==0. With WAIT_STATES=0, WAIT lasts 1 cycle.
- DONE:
  - Read: cpu_in <= selected byte of sram_dq_i (addr[0]=1 gives [15:8]).
  - Write: sram_we_n deasserts first; dq_oe drops in the same cycle, so data holds through the we_n rising edge.
  - cpu_chipen=1 for exactly this cycle. All strobes return to 1 next cycle.
- Latency:
  - Address presented to cpu_chipen=1 is 3+WAIT_STATES cycles.
  - Exactly one access per chipen pulse.
- cpu_in holds its last value between reads. Writes do not modify cpu_in.
- The CPU must not change address/we/out while chipen=0. The bridge uses only the values latched in IDLE.
- Address wrap: the 20-bit address maps directly, with no wrap handling (the CPU already wraps at FFFFF).

Optional Feature:
- Macro: K8088_SRAM_PREFETCH_EN.
- Enabled:
  - One-word buffer {valid, tag[18:0], data[15:0]}, filled on every completed read.
  - A read in IDLE whose address[19:1] equals the tag while valid=1 skips SRAM: next cycle is DONE with data from the buffer. Latency 1.
  - A write whose word matches the tag updates the corresponding buffer byte in DONE.
  - Reset clears valid.
- Disabled: no buffer; every access takes the full path.

Decomposition:
- Package k8088_sram_pkg holds:
  - the state enum (IDLE, SETUP, WAIT, DONE), 2 bits;
  - byte-lane select constants;
  - the wait-counter width (4).
- Natural sub-module: k8088_sram_prefetch (tag compare, buffer, byte update), instantiated only under the macro.

Test Plan:
- Reset held, then released: cpu_chipen=0, ce_n/oe_n/we_n=1, cpu_in=00. First access at address 00000 yields chipen pulse after 3+WAIT_STATES cycles.
- Read 12345h with SRAM word 091A2h = ABCDh: ub selected, cpu_in=ABh at the chipen pulse. Then read 12344h gives CDh with lb selected.
- Write 5Ah to 00003h (WAIT_STATES=2): we_n low 3 cycles, ub_n=0, lb_n=1, dq_o=5A5Ah. chipen pulses at cycle 5. Readback yields 5Ah.
- Reset asserted during WAIT of a write: we_n=1 and dq_oe=0 within the same cycle. SRAM model shows no byte change.
- Prefetch enabled: reads at 00100h then 00101h. Second read shows no ce_n activity and chipen 1 cycle after IDLE.
- Prefetch enabled: write 77h to 00101h, then read 00101h hits the buffer and returns 77h.
